// File: rtl/imm_prefix_controller.sv
// imm_prefix_controller
//   Builds wide immediates for the 16-bit CPU from a run of 4-bit prefix
//   instructions followed by a final instruction that supplies the last
//   nibble. The assembled value is sign-extended, zero-extended or forced
//   to zero, then registered for the ALU/address path.
//
//   Optional feature: define IMM_PREFIX_TIMEOUT_EN to discard a run that
//   sits idle for TIMEOUT_CYCLES cycles. When it is undefined, prefix_timeout
//   is tied low and a run is held until it completes, is flushed or is reset.
//
// Ports
//   clk                     rising-edge clock
//   reset_n                 synchronous active-low reset
//   instr_valid             decode presents an instruction
//   is_prefix               presented instruction is a prefix
//   Immediate[3:0]          prefix payload or final immediate nibble
//   ImmediateSourceControl  00 sign-ext, 01 zero-ext, 1x force zero (final only)
//   stall                   hold all state, accept nothing
//   flush                   drop any pending run (beats a same-cycle instruction)
//   Immediate_Extension     registered 16-bit result, held between pulses
//   imm_valid               1-cycle pulse, Immediate_Extension updated
//   prefix_pending          at least one prefix held
//   prefix_overflow         1-cycle pulse, a 4th prefix pushed out the oldest nibble
//   prefix_timeout          1-cycle pulse, idle run discarded
module imm_prefix_controller #(
   parameter int TIMEOUT_CYCLES = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        instr_valid,
   input  logic        is_prefix,
   input  logic [3:0]  Immediate,
   input  logic [1:0]  ImmediateSourceControl,
   input  logic        stall,
   input  logic        flush,
   output logic [15:0] Immediate_Extension,
   output logic        imm_valid,
   output logic        prefix_pending,
   output logic        prefix_overflow,
   output logic        prefix_timeout
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be within 1..255");
   end

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t      state_q, state_d;
   logic [11:0] acc_q, acc_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [15:0] ext_d;
   logic        vld_d, ovf_d;
   logic        accept;

   // Final-instruction datapath: raw value zero-extended, plus the mask of
   // bits above the raw width that a sign extension has to fill.
   logic [15:0] raw;
   logic [15:0] sext_mask;
   logic        sign_bit;

   assign accept = instr_valid & ~stall & ~flush;

   always_comb begin
      raw       = {acc_q, Immediate};
      sext_mask = 16'h0000;
      sign_bit  = acc_q[11];
      case (cnt_q)
         2'd0: begin raw = {12'h000, Immediate};       sext_mask = 16'hFFF0; sign_bit = Immediate[3]; end
         2'd1: begin raw = {8'h00, acc_q[3:0], Immediate}; sext_mask = 16'hFF00; sign_bit = acc_q[3];  end
         2'd2: begin raw = {4'h0, acc_q[7:0], Immediate};  sext_mask = 16'hF000; sign_bit = acc_q[7];  end
         default: begin raw = {acc_q, Immediate};       sext_mask = 16'h0000; sign_bit = acc_q[11]; end
      endcase
   end

`ifdef IMM_PREFIX_TIMEOUT_EN
   logic [7:0] idle_q, idle_d;
   logic [7:0] idle_inc;
   logic       to_d;

   // Saturate so a very long stall cannot wrap the counter past the limit.
   assign idle_inc = (idle_q == 8'hFF) ? idle_q : idle_q + 8'd1;
`endif

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ext_d   = Immediate_Extension;
      vld_d   = 1'b0;
      ovf_d   = 1'b0;
`ifdef IMM_PREFIX_TIMEOUT_EN
      idle_d  = idle_q;
      to_d    = 1'b0;
`endif
      if (flush) begin
         acc_d   = 12'h000;
         cnt_d   = 2'd0;
         state_d = IDLE;
`ifdef IMM_PREFIX_TIMEOUT_EN
         idle_d  = 8'd0;
`endif
      end else if (accept) begin
`ifdef IMM_PREFIX_TIMEOUT_EN
         idle_d = 8'd0;
`endif
         if (is_prefix) begin
            acc_d   = {acc_q[7:0], Immediate};
            state_d = ACCUM;
            if (cnt_q == 2'd3) ovf_d = 1'b1;   // oldest nibble falls off the top
            else               cnt_d = cnt_q + 2'd1;
         end else begin
            case (ImmediateSourceControl)
               2'b00:   ext_d = sign_bit ? (raw | sext_mask) : raw;
               2'b01:   ext_d = raw;
               default: ext_d = 16'h0000;
            endcase
            vld_d   = 1'b1;
            acc_d   = 12'h000;
            cnt_d   = 2'd0;
            state_d = IDLE;
         end
      end
`ifdef IMM_PREFIX_TIMEOUT_EN
      else if (state_q == ACCUM) begin
         // Idle time accrues through stalls too, but the discard itself is
         // deferred until the pipeline is moving so stall keeps state frozen.
         idle_d = idle_inc;
         if (!stall && idle_inc >= 8'(TIMEOUT_CYCLES)) begin
            acc_d   = 12'h000;
            cnt_d   = 2'd0;
            state_d = IDLE;
            idle_d  = 8'd0;
            to_d    = 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q             <= IDLE;
         acc_q               <= 12'h000;
         cnt_q               <= 2'd0;
         Immediate_Extension <= 16'h0000;
         imm_valid           <= 1'b0;
         prefix_pending      <= 1'b0;
         prefix_overflow     <= 1'b0;
      end else begin
         state_q             <= state_d;
         acc_q               <= acc_d;
         cnt_q               <= cnt_d;
         Immediate_Extension <= ext_d;
         imm_valid           <= vld_d;
         prefix_pending      <= (cnt_d != 2'd0);
         prefix_overflow     <= ovf_d;
      end
   end

`ifdef IMM_PREFIX_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         idle_q         <= 8'd0;
         prefix_timeout <= 1'b0;
      end else begin
         idle_q         <= idle_d;
         prefix_timeout <= to_d;
      end
   end
`else
   assign prefix_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_imm_prefix_controller.sv
// Self-checking bench for imm_prefix_controller. Expected immediates are
// pushed to a queue when a final instruction is driven and popped when
// imm_valid is seen.
module tb_imm_prefix_controller;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        instr_valid;
   logic        is_prefix;
   logic [3:0]  Immediate;
   logic [1:0]  ImmediateSourceControl;
   logic        stall;
   logic        flush;
   logic [15:0] Immediate_Extension;
   logic        imm_valid;
   logic        prefix_pending;
   logic        prefix_overflow;
   logic        prefix_timeout;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_q[$];
   logic [15:0] exp;

   imm_prefix_controller #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .is_prefix(is_prefix),
      .Immediate(Immediate), .ImmediateSourceControl(ImmediateSourceControl),
      .stall(stall), .flush(flush), .Immediate_Extension(Immediate_Extension),
      .imm_valid(imm_valid), .prefix_pending(prefix_pending),
      .prefix_overflow(prefix_overflow), .prefix_timeout(prefix_timeout)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic v, input logic p, input logic [3:0] imm,
                         input logic [1:0] mode, input logic st, input logic fl);
      instr_valid = v; is_prefix = p; Immediate = imm;
      ImmediateSourceControl = mode; stall = st; flush = fl;
   endtask

   task automatic idle();
      set_in(1'b0, 1'b0, 4'h0, 2'b00, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      idle();
      tick(); tick();
      checks++; if (Immediate_Extension !== 16'h0000) begin errors++; $display("FAIL reset_ext: got %h want 0000", Immediate_Extension); end
      checks++; if (imm_valid !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", imm_valid); end
      checks++; if (prefix_pending !== 1'b0) begin errors++; $display("FAIL reset_pend: got %b want 0", prefix_pending); end
      checks++; if (prefix_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", prefix_overflow); end
      checks++; if (prefix_timeout !== 1'b0) begin errors++; $display("FAIL reset_to: got %b want 0", prefix_timeout); end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      logic [3:0]  imms [3] = '{4'hA, 4'hA, 4'hA};
      logic [1:0]  modes[3] = '{2'b00, 2'b01, 2'b10};
      logic [15:0] res  [3] = '{16'hFFFA, 16'h000A, 16'h0000};
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 1'b0, imms[i], modes[i], 1'b0, 1'b0);
         exp_q.push_back(res[i]);
         tick();
         idle();
         checks++;
         if (imm_valid !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL single_vld[%0d]: got %b want 1", i, imm_valid);
         end else begin
            exp = exp_q.pop_front();
            checks++; if (Immediate_Extension !== exp) begin errors++; $display("FAIL single_ext[%0d]: got %h want %h", i, Immediate_Extension, exp); end
         end
         tick();
         checks++; if (imm_valid !== 1'b0) begin errors++; $display("FAIL single_pulse[%0d]: got %b want 0", i, imm_valid); end
         checks++; if (Immediate_Extension !== res[i]) begin errors++; $display("FAIL single_hold[%0d]: got %h want %h", i, Immediate_Extension, res[i]); end
      end
   endtask

   task automatic test_prefix12();
      logic [1:0]  modes[2] = '{2'b00, 2'b01};
      logic [15:0] res  [2] = '{16'hF813, 16'h0813};
      for (int i = 0; i < 2; i++) begin
         set_in(1'b1, 1'b1, 4'h8, 2'b11, 1'b0, 1'b0); tick();
         checks++; if (prefix_pending !== 1'b1) begin errors++; $display("FAIL p12_pend1[%0d]: got %b want 1", i, prefix_pending); end
         set_in(1'b1, 1'b1, 4'h1, 2'b11, 1'b0, 1'b0); tick();
         checks++; if (prefix_pending !== 1'b1) begin errors++; $display("FAIL p12_pend2[%0d]: got %b want 1", i, prefix_pending); end
         set_in(1'b1, 1'b0, 4'h3, modes[i], 1'b0, 1'b0);
         exp_q.push_back(res[i]);
         tick(); idle();
         checks++;
         if (imm_valid !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL p12_vld[%0d]: got %b want 1", i, imm_valid);
         end else begin
            exp = exp_q.pop_front();
            checks++; if (Immediate_Extension !== exp) begin errors++; $display("FAIL p12_ext[%0d]: got %h want %h", i, Immediate_Extension, exp); end
         end
         checks++; if (prefix_pending !== 1'b0) begin errors++; $display("FAIL p12_pend_clr[%0d]: got %b want 0", i, prefix_pending); end
      end
   endtask

   task automatic test_overflow();
      for (int n = 1; n <= 4; n++) begin
         set_in(1'b1, 1'b1, 4'(n), 2'b00, 1'b0, 1'b0); tick();
         checks++;
         if (prefix_overflow !== (n == 4)) begin errors++; $display("FAIL ovf_pulse[%0d]: got %b want %b", n, prefix_overflow, (n == 4)); end
      end
      set_in(1'b1, 1'b0, 4'h5, 2'b00, 1'b0, 1'b0);
      exp_q.push_back(16'h2345);
      tick(); idle();
      checks++; if (prefix_overflow !== 1'b0) begin errors++; $display("FAIL ovf_once: got %b want 0", prefix_overflow); end
      checks++;
      if (imm_valid !== 1'b1 || exp_q.size() == 0) begin
         errors++; $display("FAIL ovf_vld: got %b want 1", imm_valid);
      end else begin
         exp = exp_q.pop_front();
         checks++; if (Immediate_Extension !== exp) begin errors++; $display("FAIL ovf_ext: got %h want %h", Immediate_Extension, exp); end
      end
   endtask

   task automatic test_full16();
      logic [1:0] modes[2] = '{2'b00, 2'b01};
      for (int i = 0; i < 2; i++) begin
         set_in(1'b1, 1'b1, 4'h8, 2'b00, 1'b0, 1'b0); tick();
         set_in(1'b1, 1'b1, 4'h0, 2'b00, 1'b0, 1'b0); tick();
         set_in(1'b1, 1'b1, 4'h0, 2'b00, 1'b0, 1'b0); tick();
         set_in(1'b1, 1'b0, 4'h1, modes[i], 1'b0, 1'b0);
         exp_q.push_back(16'h8001);
         tick(); idle();
         checks++;
         if (imm_valid !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL full16_vld[%0d]: got %b want 1", i, imm_valid);
         end else begin
            exp = exp_q.pop_front();
            checks++; if (Immediate_Extension !== exp) begin errors++; $display("FAIL full16_ext[%0d]: got %h want %h", i, Immediate_Extension, exp); end
         end
      end
   endtask

   task automatic test_flush();
      set_in(1'b1, 1'b1, 4'h7, 2'b00, 1'b0, 1'b0); tick();
      set_in(1'b1, 1'b0, 4'h1, 2'b00, 1'b0, 1'b1); tick();
      checks++; if (imm_valid !== 1'b0) begin errors++; $display("FAIL flush_vld: got %b want 0", imm_valid); end
      checks++; if (prefix_pending !== 1'b0) begin errors++; $display("FAIL flush_pend: got %b want 0", prefix_pending); end
      checks++; if (Immediate_Extension !== 16'h8001) begin errors++; $display("FAIL flush_hold: got %h want 8001", Immediate_Extension); end
      set_in(1'b1, 1'b0, 4'h1, 2'b00, 1'b0, 1'b0);
      exp_q.push_back(16'h0001);
      tick(); idle();
      checks++;
      if (imm_valid !== 1'b1 || exp_q.size() == 0) begin
         errors++; $display("FAIL flush_next_vld: got %b want 1", imm_valid);
      end else begin
         exp = exp_q.pop_front();
         checks++; if (Immediate_Extension !== exp) begin errors++; $display("FAIL flush_next_ext: got %h want %h", Immediate_Extension, exp); end
      end
   endtask

   task automatic test_stall();
      set_in(1'b1, 1'b1, 4'hF, 2'b00, 1'b0, 1'b0); tick();
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 1'b0, 4'h0, 2'b00, 1'b1, 1'b0); tick();
         checks++; if (imm_valid !== 1'b0) begin errors++; $display("FAIL stall_vld[%0d]: got %b want 0", i, imm_valid); end
         checks++; if (prefix_pending !== 1'b1) begin errors++; $display("FAIL stall_pend[%0d]: got %b want 1", i, prefix_pending); end
      end
      set_in(1'b1, 1'b0, 4'h0, 2'b00, 1'b0, 1'b0);
      exp_q.push_back(16'hFFF0);
      tick(); idle();
      checks++;
      if (imm_valid !== 1'b1 || exp_q.size() == 0) begin
         errors++; $display("FAIL stall_done_vld: got %b want 1", imm_valid);
      end else begin
         exp = exp_q.pop_front();
         checks++; if (Immediate_Extension !== exp) begin errors++; $display("FAIL stall_done_ext: got %h want %h", Immediate_Extension, exp); end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0]  imms [3] = '{4'h8, 4'h8, 4'h7};
      logic [1:0]  modes[3] = '{2'b00, 2'b01, 2'b11};
      logic [15:0] res  [3] = '{16'hFFF8, 16'h0008, 16'h0000};
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 1'b0, imms[i], modes[i], 1'b0, 1'b0);
         exp_q.push_back(res[i]);
         tick();
         checks++;
         if (imm_valid !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL b2b_vld[%0d]: got %b want 1", i, imm_valid);
         end else begin
            exp = exp_q.pop_front();
            checks++; if (Immediate_Extension !== exp) begin errors++; $display("FAIL b2b_ext[%0d]: got %h want %h", i, Immediate_Extension, exp); end
         end
      end
      idle(); tick();
      checks++; if (imm_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b want 0", imm_valid); end
   endtask

   task automatic test_reset_midrun();
      set_in(1'b1, 1'b1, 4'h9, 2'b00, 1'b0, 1'b0); tick();
      reset_n = 1'b0;
      set_in(1'b1, 1'b0, 4'h4, 2'b00, 1'b0, 1'b0); tick();
      checks++; if (prefix_pending !== 1'b0) begin errors++; $display("FAIL rst_mid_pend: got %b want 0", prefix_pending); end
      checks++; if (imm_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_vld: got %b want 0", imm_valid); end
      checks++; if (Immediate_Extension !== 16'h0000) begin errors++; $display("FAIL rst_mid_ext: got %h want 0000", Immediate_Extension); end
      reset_n = 1'b1;
      set_in(1'b1, 1'b0, 4'h3, 2'b00, 1'b0, 1'b0);
      exp_q.push_back(16'h0003);
      tick(); idle();
      checks++;
      if (imm_valid !== 1'b1 || exp_q.size() == 0) begin
         errors++; $display("FAIL rst_mid_next_vld: got %b want 1", imm_valid);
      end else begin
         exp = exp_q.pop_front();
         checks++; if (Immediate_Extension !== exp) begin errors++; $display("FAIL rst_mid_next_ext: got %h want %h", Immediate_Extension, exp); end
      end
   endtask

   task automatic test_timeout();
      set_in(1'b1, 1'b1, 4'h5, 2'b00, 1'b0, 1'b0); tick();
      idle();
`ifdef IMM_PREFIX_TIMEOUT_EN
      for (int i = 1; i <= 4; i++) begin
         tick();
         checks++; if (prefix_timeout !== (i == 4)) begin errors++; $display("FAIL to_pulse[%0d]: got %b want %b", i, prefix_timeout, (i == 4)); end
         checks++; if (prefix_pending !== (i != 4)) begin errors++; $display("FAIL to_pend[%0d]: got %b want %b", i, prefix_pending, (i != 4)); end
      end
      tick();
      checks++; if (prefix_timeout !== 1'b0) begin errors++; $display("FAIL to_once: got %b want 0", prefix_timeout); end
      set_in(1'b1, 1'b0, 4'h2, 2'b01, 1'b0, 1'b0);
      exp_q.push_back(16'h0002);
      tick(); idle();
      checks++;
      if (imm_valid !== 1'b1 || exp_q.size() == 0) begin
         errors++; $display("FAIL to_next_vld: got %b want 1", imm_valid);
      end else begin
         exp = exp_q.pop_front();
         checks++; if (Immediate_Extension !== exp) begin errors++; $display("FAIL to_next_ext: got %h want %h", Immediate_Extension, exp); end
      end
      // Final instruction on the expiry edge completes the run instead.
      set_in(1'b1, 1'b1, 4'h5, 2'b00, 1'b0, 1'b0); tick();
      idle(); tick(); tick(); tick();
      set_in(1'b1, 1'b0, 4'h2, 2'b01, 1'b0, 1'b0);
      exp_q.push_back(16'h0052);
      tick(); idle();
      checks++; if (prefix_timeout !== 1'b0) begin errors++; $display("FAIL to_race: got %b want 0", prefix_timeout); end
`else
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++; if (prefix_timeout !== 1'b0 || prefix_pending !== 1'b1) begin
            errors++; $display("FAIL noto_hold[%0d]: timeout=%b pend=%b want 0/1", i, prefix_timeout, prefix_pending);
         end
      end
      set_in(1'b1, 1'b0, 4'h2, 2'b01, 1'b0, 1'b0);
      exp_q.push_back(16'h0052);
      tick(); idle();
`endif
      checks++;
      if (imm_valid !== 1'b1 || exp_q.size() == 0) begin
         errors++; $display("FAIL to_run_vld: got %b want 1", imm_valid);
      end else begin
         exp = exp_q.pop_front();
         checks++; if (Immediate_Extension !== exp) begin errors++; $display("FAIL to_run_ext: got %h want %h", Immediate_Extension, exp); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_prefix12();
      test_overflow();
      test_full16();
      test_flush();
      test_stall();
      test_back_to_back();
      test_reset_midrun();
      test_timeout();
      tick();
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_drain: %0d results never seen, want 0", exp_q.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/imm_prefix_controller.md
# imm_prefix_controller

Sequencer for the immediate-extension datapath of the 16-bit single-cycle CPU. It assembles wide immediates from a run of 4-bit prefix instructions plus the final instruction's 4-bit immediate. It then sign- or zero-extends the result to 16 bits and presents it to the ALU/address path one cycle later. Pipeline flush and stall control it, and it flags malformed prefix runs.

## Interface
Parameters:
- TIMEOUT_CYCLES, 8: idle cycles allowed between prefixes before discard; used only under IMM_PREFIX_TIMEOUT_EN. Legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
- instr_valid  input  1  decode presents an instruction this cycle.
- is_prefix  input  1  presented instruction is an immediate prefix.
- Immediate  input  4  nibble from the instruction, either prefix payload or final immediate.
- ImmediateSourceControl  input  2  00 sign-extend, 01 zero-extend, 10/11 force zero. Sampled only on final instruction.
- stall  input  1  pipeline stall; nothing is accepted while high.
- flush  input  1  discards any pending prefix run.
- Immediate_Extension  output  16  registered extended immediate.
- imm_valid  output  1  one-cycle pulse, Immediate_Extension updated.
- prefix_pending  output  1  at least one prefix held.
- prefix_overflow  output  1  one-cycle pulse, a fourth prefix was accepted.
- prefix_timeout  output  1  one-cycle pulse, pending run discarded by timeout (0 when feature off).

## Operation
- State: 12-bit accumulator acc, 2-bit count (0..3), FSM {IDLE, ACCUM}. IDLE ⇔ count==0.
- Accept = instr_valid & ~stall & ~flush.
- Prefix accepted:
  - acc ← {acc[7:0], Immediate}.
  - count ← min(count+1, 3).
  - State → ACCUM.
- Prefix accepted with count==3:
  - Oldest nibble is shifted out and count stays 3.
  - prefix_overflow pulses next cycle.
- Final (non-prefix) instruction accepted:
  - Raw value is N = 4·(count+1) bits: {acc[4·count−1:0], Immediate}.
  - Mode 00: Immediate_Extension ← raw sign-extended from bit N−1.
  - Mode 01: Immediate_Extension ← raw zero-extended.
  - Mode 10/11: Immediate_Extension ← 16'h0000.
  - count==3 gives exactly 16 bits and no extension.
  - imm_valid pulses, acc ← 0, count ← 0, state → IDLE.
- flush high: acc ← 0, count ← 0, state → IDLE. Flush beats a simultaneous instruction, so no imm_valid and no overflow.
- stall high: all state holds. imm_valid, prefix_overflow and prefix_timeout are 0.
- Immediate_Extension holds its last value between pulses.
- prefix_pending = (count != 0), driven from registered state.

## Timing
- Reset (reset_n low at clk edge) sets:
  - Immediate_Extension = 16'h0000.
  - imm_valid, prefix_pending, prefix_overflow, prefix_timeout = 0.
  - acc = 0, count = 0, state IDLE.
- Reset overrides every other input, including mid-run; the pending run is lost.
- Latency: final instruction accepted at edge k → Immediate_Extension/imm_valid valid after edge k, held through edge k+1. imm_valid lasts exactly one cycle.
- Back-to-back final instructions give imm_valid on consecutive cycles.
- Prefix at edge k → prefix_pending high after edge k.
- A prefix and the final instruction never occur in the same cycle, since there is one instruction per cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- IMM_PREFIX_TIMEOUT_EN defined:
  - An 8-bit idle counter runs in ACCUM. It increments on every cycle with no accepted instruction, including stalled cycles, and clears on any accepted instruction.
  - On reaching TIMEOUT_CYCLES, the run is discarded (acc, count ← 0, IDLE) and prefix_timeout pulses one cycle.
  - A final instruction arriving on the same edge as expiry wins: it completes normally and no timeout is raised.
- Undefined:
  - The counter is absent and prefix_timeout is tied 0.
  - Runs persist indefinitely until completed, flushed or reset.

## Test plan
- Reset, then final instruction with Immediate=4'hA, mode 00 → next cycle Immediate_Extension=16'hFFFA, imm_valid=1 for one cycle. Repeat with mode 01 → 16'h000A.
- Prefixes 4'h8, 4'h1, then final 4'h3, mode 00 → 16'hF813 (12-bit sign). Same run in mode 01 → 16'h0813. prefix_pending is high for the two cycles before the pulse.
- Prefixes 1,2,3,4 then final 5, mode 00 → prefix_overflow pulses once after the 4th prefix and the result is 16'h2345.
- Prefix 4'h7, then flush asserted together with final 4'h1 → no imm_valid and prefix_pending=0. The next final 4'h1 (mode 00) → 16'h0001.
- Prefix 4'hF, stall high for 3 cycles, then final 4'h0, mode 00 → no pulses during the stall, then 16'hFFF0.
- With IMM_PREFIX_TIMEOUT_EN and TIMEOUT_CYCLES=4: prefix 4'h5, then 4 idle cycles → prefix_timeout pulse and prefix_pending=0. The next final 4'h2, mode 01 → 16'h0002.
